// File: rtl/imm_pkg.sv
// Shared types and ImmSrc encodings for the immediate extender.
// IMM_EXT_MAX / IMM_TAG_MAX bound DATA_W (<=64) and TAG_W (<=32).
package imm_pkg;

  localparam logic [1:0] IMM_DP   = 2'b00;
  localparam logic [1:0] IMM_MEM  = 2'b01;
  localparam logic [1:0] IMM_BR   = 2'b10;
  localparam logic [1:0] IMM_HALF = 2'b11;

  localparam int IMM_EXT_MAX = 64;
  localparam int IMM_TAG_MAX = 32;

  typedef struct packed {
    logic [IMM_EXT_MAX-1:0] ext;
    logic                   carry;
    logic                   carry_valid;
    logic                   illegal;
    logic [IMM_TAG_MAX-1:0] tag;
  } imm_res_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational Imm/ImmSrc to imm_res_t mapping.
// Macro IMM_HALFWORD_EN enables the LDRH/STRH split immediate on ImmSrc=11.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int TAG_W    = 8,
  parameter int BR_SHIFT = 2
) (
  input  logic [23:0]      imm,
  input  logic [1:0]       src,
  input  logic [TAG_W-1:0] tag,
  output imm_res_t         res
);

  logic [31:0] imm8_w;
  logic [31:0] rot_val;
  logic [4:0]  amt;
  logic [63:0] br_sx;

  assign imm8_w  = {24'b0, imm[7:0]};
  assign amt     = {imm[11:8], 1'b0};
  // A shift by 32 yields zero, so rot=0 leaves imm8 unchanged.
  assign rot_val = (imm8_w >> amt)
                 | (imm8_w << (6'd32 - {1'b0, amt}));
  assign br_sx   = {{40{imm[23]}}, imm} << BR_SHIFT;

  always_comb begin
    res     = '0;
    res.tag = IMM_TAG_MAX'(tag);
    unique case (1'b1)
      (src == IMM_DP): begin
        res.ext         = 64'(rot_val);
        res.carry_valid = |imm[11:8];
        res.carry       = (|imm[11:8]) & rot_val[31];
      end
      (src == IMM_MEM): res.ext = 64'(imm[11:0]);
      (src == IMM_BR):  res.ext = br_sx;
      (src == IMM_HALF): begin
`ifdef IMM_HALFWORD_EN
        res.ext = 64'({imm[11:8], imm[3:0]});
`else
        res.illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer.
// Macro IMM_HALFWORD_EN selects the ImmSrc=11 halfword mode.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 8,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       Imm,
  input  logic [1:0]        ImmSrc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ImmExt,
  output logic              ImmCarry,
  output logic              ImmCarryValid,
  output logic              ImmIllegal,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    logic [DATA_W-1:0] ext;
    logic              c;
    logic              cv;
    logic              ill;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  imm_res_t res;
  ent_t     in_ent;
  ent_t     main_q;
  ent_t     skid_q;
  logic     main_v;
  logic     skid_v;
  logic     acc;
  logic     unused_res;

  imm_ext_core #(
    .TAG_W    (TAG_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .imm (Imm),
    .src (ImmSrc),
    .tag (in_tag),
    .res (res)
  );

  always_comb begin
    in_ent     = '0;
    in_ent.ext = res.ext[DATA_W-1:0];
    in_ent.c   = res.carry;
    in_ent.cv  = res.carry_valid;
    in_ent.ill = res.illegal;
    in_ent.tag = res.tag[TAG_W-1:0];
  end

  assign unused_res = ^{res.ext, res.tag};

  assign in_ready = !skid_v;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      // Skid only holds data while in_ready is low, so no accept here.
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= acc;
        if (acc) main_q <= in_ent;
      end
    end else if (acc) begin
      skid_q <= in_ent;
      skid_v <= 1'b1;
    end
  end

  assign out_valid     = main_v;
  assign ImmExt        = main_q.ext;
  assign ImmCarry      = main_q.c;
  assign ImmCarryValid = main_q.cv;
  assign ImmIllegal    = main_q.ill;
  assign out_tag       = main_q.tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe (DATA_W=32, TAG_W=8, BR_SHIFT=2).
// Honours IMM_HALFWORD_EN for the expected ImmSrc=11 results.
module tb_imm_ext_pipe;

  localparam int DW = 32;
  localparam int TW = 8;
  localparam int BS = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          flush = 0;
  logic          in_valid = 0;
  logic          out_ready = 0;
  logic [23:0]   imm = 0;
  logic [1:0]    src = 0;
  logic [TW-1:0] in_tag = 0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] ImmExt;
  logic          ImmCarry;
  logic          ImmCarryValid;
  logic          ImmIllegal;
  logic [TW-1:0] out_tag;

  int vectors = 0;
  int errs = 0;

  typedef struct {
    logic [31:0] ext;
    logic        c;
    logic        cv;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];

  imm_ext_pipe #(.DATA_W(DW), .TAG_W(TW), .BR_SHIFT(BS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Imm(imm), .ImmSrc(src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .ImmExt(ImmExt), .ImmCarry(ImmCarry),
    .ImmCarryValid(ImmCarryValid), .ImmIllegal(ImmIllegal),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic exp_t model(logic [23:0] i, logic [1:0] s,
                                 logic [7:0] t);
    exp_t   e;
    longint off;
    int     r;
    e.ext = 0; e.c = 0; e.cv = 0; e.ill = 0; e.tag = t;
    case (s)
      2'd0: begin
        r = 2 * i[11:8];
        e.ext = {24'b0, i[7:0]};
        for (int k = 0; k < r; k++) e.ext = {e.ext[0], e.ext[31:1]};
        if (r != 0) begin e.cv = 1; e.c = e.ext[31]; end
      end
      2'd1: e.ext = {20'b0, i[11:0]};
      2'd2: begin
        off = longint'(i);
        if (i[23]) off = off - 64'sd16777216;
        off = off * (64'sd1 << BS);
        e.ext = off[31:0];
      end
      default: begin
`ifdef IMM_HALFWORD_EN
        e.ext = i[11:8] * 16 + i[3:0];
`else
        e.ill = 1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    vectors++;
    if (out_valid !== 1'b0) begin errs++;
      $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin errs++;
      $display("FAIL rst_in_ready got %b want 1", in_ready); end
    vectors++;
    if (ImmExt !== '0) begin errs++;
      $display("FAIL rst_ext got %h want 0", ImmExt); end
    vectors++;
    if ({ImmCarry, ImmCarryValid, ImmIllegal} !== 3'b000) begin errs++;
      $display("FAIL rst_flags got %b want 000",
               {ImmCarry, ImmCarryValid, ImmIllegal}); end
    vectors++;
    if (out_tag !== '0) begin errs++;
      $display("FAIL rst_tag got %h want 0", out_tag); end
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_dp();
    out_ready = 1;
    imm = 24'h0004FF; src = 2'b00; in_tag = 8'h5A; in_valid = 1;
    vectors++;
    if (in_ready !== 1'b1) begin errs++;
      $display("FAIL dp_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    vectors++;
    if (out_valid !== 1'b1) begin errs++;
      $display("FAIL dp_latency got %b want 1", out_valid); end
    vectors++;
    if (ImmExt !== 32'hFF000000) begin errs++;
      $display("FAIL dp_ext got %h want ff000000", ImmExt); end
    vectors++;
    if ({ImmCarry, ImmCarryValid} !== 2'b11) begin errs++;
      $display("FAIL dp_carry got %b want 11", {ImmCarry, ImmCarryValid}); end
    vectors++;
    if (out_tag !== 8'h5A) begin errs++;
      $display("FAIL dp_tag got %h want 5a", out_tag); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errs++;
      $display("FAIL dp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_modes();
    logic [23:0] ti[5];
    logic [1:0]  ts[5];
    logic [31:0] te[5];
    logic        tl[5];
    ti = '{24'h00002A, 24'hABCFFF, 24'hFFFFFE, 24'h000010, 24'h000A05};
    ts = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
`ifdef IMM_HALFWORD_EN
    te = '{32'h2A, 32'hFFF, 32'hFFFFFFF8, 32'h40, 32'hA5};
    tl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    te = '{32'h2A, 32'hFFF, 32'hFFFFFFF8, 32'h40, 32'h0};
    tl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      imm = ti[k]; src = ts[k]; in_tag = 8'(k + 8'h30); in_valid = 1;
      tick();
      in_valid = 0;
      vectors++;
      if (out_valid !== 1'b1 || ImmExt !== te[k]) begin errs++;
        $display("FAIL mode%0d_ext got v=%b %h want v=1 %h",
                 k, out_valid, ImmExt, te[k]); end
      vectors++;
      if ({ImmCarry, ImmCarryValid, ImmIllegal} !== {2'b00, tl[k]}) begin
        errs++;
        $display("FAIL mode%0d_flags got %b want %b", k,
                 {ImmCarry, ImmCarryValid, ImmIllegal}, {2'b00, tl[k]}); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] bi[4];
    exp_t        e;
    for (int k = 1; k < 4; k++) bi[k] = 24'($urandom);
    src = 2'b01; out_ready = 0; in_valid = 1;
    imm = bi[1]; in_tag = 8'd1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 8'd1 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_first got v=%b tag=%0d rdy=%b want 1,1,1",
               out_valid, out_tag, in_ready); end
    imm = bi[2]; in_tag = 8'd2;
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin errs++;
      $display("FAIL bp_ready_drop got %b want 0", in_ready); end
    imm = bi[3]; in_tag = 8'd3;
    tick();
    e = model(bi[1], 2'b01, 8'd1);
    vectors++;
    if (in_ready !== 1'b0 || out_tag !== 8'd1 || ImmExt !== e.ext) begin
      errs++;
      $display("FAIL bp_hold got rdy=%b tag=%0d ext=%h want 0,1,%h",
               in_ready, out_tag, ImmExt, e.ext); end
    out_ready = 1;
    tick();
    e = model(bi[2], 2'b01, 8'd2);
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 8'd2 || ImmExt !== e.ext) begin
      errs++;
      $display("FAIL bp_second got v=%b tag=%0d ext=%h want 1,2,%h",
               out_valid, out_tag, ImmExt, e.ext); end
    vectors++;
    if (in_ready !== 1'b1) begin errs++;
      $display("FAIL bp_ready_back got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    e = model(bi[3], 2'b01, 8'd3);
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 8'd3 || ImmExt !== e.ext) begin
      errs++;
      $display("FAIL bp_third got v=%b tag=%0d ext=%h want 1,3,%h",
               out_valid, out_tag, ImmExt, e.ext); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errs++;
      $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    src = 2'b01; imm = 24'h000123; out_ready = 0; in_valid = 1;
    in_tag = 8'h10;
    tick();
    in_tag = 8'h11;
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin errs++;
      $display("FAIL fl_full got %b want 0", in_ready); end
    flush = 1; in_tag = 8'h12;
    tick();
    flush = 0; in_valid = 0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++;
      $display("FAIL fl_clear got v=%b rdy=%b want 0,1",
               out_valid, in_ready); end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin errs++;
        $display("FAIL fl_ghost%0d got v=%b tag=%h want 0",
                 k, out_valid, out_tag); end
    end
    in_valid = 1; flush = 1; in_tag = 8'h13;
    tick();
    in_valid = 0; flush = 0;
    vectors++;
    if (out_valid !== 1'b0) begin errs++;
      $display("FAIL fl_accept got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    src = 2'b00; imm = 24'h0004FF; out_ready = 0; in_valid = 1;
    in_tag = 8'h21;
    tick();
    in_tag = 8'h22;
    tick();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++;
      $display("FAIL rm_ctrl got v=%b rdy=%b want 0,1",
               out_valid, in_ready); end
    vectors++;
    if ({ImmExt, ImmCarry, ImmCarryValid, ImmIllegal, out_tag} !== '0) begin
      errs++;
      $display("FAIL rm_data got ext=%h c=%b cv=%b il=%b tag=%h want 0",
               ImmExt, ImmCarry, ImmCarryValid, ImmIllegal, out_tag); end
    @(negedge clk);
    rst_n = 1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errs++;
      $display("FAIL rm_after got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    exp_t e;
    bit   drain;
    bit   acc;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      imm = 24'($urandom);
      src = 2'($urandom_range(0, 3));
      in_tag = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      vectors++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        errs++;
        $display("FAIL rnd_ctrl@%0d got v=%b rdy=%b want %b,%b", n,
                 out_valid, in_ready, q.size() > 0, q.size() < 2); end
      if (q.size() > 0) begin
        e = q[0];
        vectors++;
        if ({ImmExt, ImmCarry, ImmCarryValid, ImmIllegal, out_tag} !==
            {e.ext, e.c, e.cv, e.ill, e.tag}) begin
          errs++;
          $display("FAIL rnd_data@%0d got %h/%b%b%b/%h want %h/%b%b%b/%h",
                   n, ImmExt, ImmCarry, ImmCarryValid, ImmIllegal, out_tag,
                   e.ext, e.c, e.cv, e.ill, e.tag); end
      end
      if (flush) begin
        q.delete();
      end else begin
        drain = (q.size() > 0) && out_ready;
        acc = in_valid && (q.size() < 2);
        if (drain) void'(q.pop_front());
        if (acc) q.push_back(model(imm, src, in_tag));
      end
      tick();
    end
    in_valid = 0;
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_dp();
    test_modes();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
